// File: rtl/send_sound_controller.sv
// Plays the "whoosh" sample clip when a newline byte is sent over the UART.
// Define SEND_SOUND_FADE_EN to fade out the last 256 samples of the clip.
module send_sound_controller #(
    parameter int DIV          = 9071,
    parameter int ADDR_W       = 12,
    parameter int SAMPLE_COUNT = 4096
) (
    input  logic              FPGA_clock,
    input  logic              reset,
    input  logic [7:0]        text_tx,
    input  logic              text_ready_tx,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [15:0]       rom_data,
    output logic [15:0]       send_audio_output,
    output logic              playing
);

    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(DIV);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pending;
    logic [15:0]       r_out;

    logic        w_trigger;
    logic        w_tick;
    logic [15:0] w_sample;

    assign w_trigger = text_ready_tx && (text_tx == 8'h0A);
    assign w_tick    = (r_div == DIV_MAX);

`ifdef SEND_SOUND_FADE_EN
    // Remaining samples after this one; doubles as the fade ratio in the window.
    logic [31:0]        w_rem;
    logic               w_in_fade;
    logic signed [23:0] w_prod;

    assign w_rem     = 32'(SAMPLE_COUNT - 1) - 32'(r_addr);
    assign w_in_fade = (w_rem < 32'd256);
    assign w_prod    = $signed(rom_data) * $signed({1'b0, w_rem[7:0]});
    assign w_sample  = w_in_fade ? w_prod[23:8] : rom_data;
`else
    assign w_sample = rom_data;
`endif

    always_ff @(posedge FPGA_clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_addr    <= '0;
            r_pending <= 1'b0;
            r_out     <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            unique case (r_state)
                IDLE: begin
                    r_out <= '0;
                    if (w_trigger) begin
                        r_addr  <= '0;
                        r_div   <= '0;
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_trigger)
                        r_pending <= 1'b1;
                    if (w_tick) begin
                        r_out <= w_sample;
                        if (r_addr == LAST)
                            r_state <= DRAIN;
                        else
                            r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_tick) begin
                        r_out <= '0;
                        // A trigger on the drain tick restarts directly.
                        if (r_pending || w_trigger) begin
                            r_pending <= 1'b0;
                            r_addr    <= '0;
                            r_state   <= PLAY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_trigger) begin
                        r_pending <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_address       = r_addr;
    assign send_audio_output = r_out;
    assign playing           = (r_state != IDLE);

endmodule

// File: tb/tb_send_sound_controller.sv
// Bench for send_sound_controller: timed scoreboard of expected samples
// against a small ROM model with DIV=3, SAMPLE_COUNT=8.
module tb_send_sound_controller;

    localparam int DIV = 3;
    localparam int AW  = 3;
    localparam int SC  = 8;
    localparam int P   = DIV + 1;
    localparam int CLIP = SC + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    text_tx;
    logic          text_ready_tx;
    logic [AW-1:0] rom_address;
    logic [15:0]   rom_data;
    logic [15:0]   send_audio_output;
    logic          playing;

    logic [15:0] rom [SC];

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic        play;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    send_sound_controller #(
        .DIV(DIV),
        .ADDR_W(AW),
        .SAMPLE_COUNT(SC)
    ) dut (
        .FPGA_clock(clk),
        .reset(reset),
        .text_tx(text_tx),
        .text_ready_tx(text_ready_tx),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .send_audio_output(send_audio_output),
        .playing(playing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rom_data <= rom[rom_address];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_sample(int k);
`ifdef SEND_SOUND_FADE_EN
        logic signed [31:0] p;
        p = $signed(rom[k]) * (SC - 1 - k);
        return p[23:8];
`else
        return rom[k];
`endif
    endfunction

    task automatic push(input int c, input logic [15:0] v, input logic pl);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.play = pl;
        q.push_back(e);
    endtask

    // Expected stream for n back-to-back clips triggered from IDLE at cycle t.
    task automatic push_chain(input int t, input int n);
        for (int j = 0; j < n; j++) begin
            push((j == 0) ? t + 1 : t + 1 + CLIP * j * P, 16'h0, 1'b1);
            for (int k = 0; k < SC; k++)
                push(t + 1 + (k + 1 + CLIP * j) * P, exp_sample(k), 1'b1);
        end
        push(t + 1 + CLIP * n * P, 16'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("sample", {16'h0, send_audio_output}, {16'h0, e.val});
            check("playing", {31'h0, playing}, {31'h0, e.play});
        end
    end

    task automatic strobe(input logic [7:0] b);
        text_tx       = b;
        text_ready_tx = 1'b1;
        @(negedge clk);
        text_ready_tx = 1'b0;
        text_tx       = 8'h00;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done();
        int budget;
        budget = 400;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;
        for (int i = 0; i < SC; i++) rom[i] = 16'(16'h0100 * (i + 1));
        reset         = 1'b1;
        text_tx       = 8'h00;
        text_ready_tx = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", {16'h0, send_audio_output}, 0);
        check("rst_play", {31'h0, playing}, 0);
        check("rst_addr", {29'h0, rom_address}, 0);
        reset = 1'b0;

        // Non-newline bytes never start playback.
        text_tx       = 8'h41;
        text_ready_tx = 1'b1;
        repeat (12) @(negedge clk);
        text_ready_tx = 1'b0;
        check("idle_out", {16'h0, send_audio_output}, 0);
        check("idle_play", {31'h0, playing}, 0);
        repeat (2) @(negedge clk);

        // Single clip.
        t = cyc;
        push_chain(t, 1);
        strobe(8'h0A);
        wait_done();

        // Retrigger at T+10 queues one clip, T+12 is dropped.
        t = cyc;
        push_chain(t, 2);
        strobe(8'h0A);
        wait_to(t + 10);
        strobe(8'h0A);
        strobe(8'h0D);
        strobe(8'h0A);
        wait_done();

        // Trigger on the DRAIN tick restarts immediately.
        for (int i = 0; i < SC; i++) rom[i] = 16'(16'hF000 + 16'h0011 * i);
        t = cyc;
        push_chain(t, 2);
        strobe(8'h0A);
        wait_to(t + CLIP * P);
        strobe(8'h0A);
        wait_done();

        // Reset mid-clip also clears a queued retrigger.
        t = cyc;
        strobe(8'h0A);
        wait_to(t + 10);
        strobe(8'h0A);
        wait_to(t + 20);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", {16'h0, send_audio_output}, 0);
        check("mid_rst_play", {31'h0, playing}, 0);
        check("mid_rst_addr", {29'h0, rom_address}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_play", {31'h0, playing}, 0);
        t = cyc;
        push_chain(t, 1);
        strobe(8'h0A);
        wait_done();

        check("q_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
